// File: rtl/frame_buffer_port_arb.sv
// Shares MCB command port 3 between frame write and read paths; one burst per grant, 4-cycle minimum spacing.
// Optional macro FB_ARB_ROUND_ROBIN_EN: alternate grants on ties (default build: read wins ties).
module frame_buffer_port_arb #(
    parameter int BURST_LEN       = 32,
    parameter int FRAME_ADDR_BITS = 24,
    parameter int RD_FIFO_DEPTH   = 64
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic                       i_calib_done,
    input  logic                       i_wr_req,
    input  logic [1:0]                 iv_wr_frame,
    input  logic [FRAME_ADDR_BITS-1:0] iv_wr_offset,
    output logic                       o_wr_ack,
    input  logic                       i_rd_req,
    input  logic [1:0]                 iv_rd_frame,
    input  logic [FRAME_ADDR_BITS-1:0] iv_rd_offset,
    output logic                       o_rd_ack,
    input  logic [6:0]                 iv_p_wr_count,
    input  logic                       i_p_rd_en,
    input  logic                       i_p_cmd_full,
    output logic                       o_p_cmd_en,
    output logic [2:0]                 ov_p_cmd_instr,
    output logic [5:0]                 ov_p_cmd_bl,
    output logic [29:0]                ov_p_cmd_byte_addr,
    output logic                       o_busy
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CMD, S_GAP} state_t;

    localparam int              AW        = FRAME_ADDR_BITS + 2;
    localparam logic [AW-1:0]   ADDR_MASK = {{(AW-2){1'b1}}, 2'b00};
    localparam logic [7:0]      BL8       = 8'(BURST_LEN);
    localparam logic [7:0]      DEPTH8    = 8'(RD_FIFO_DEPTH);
    localparam logic [6:0]      BL7       = 7'(BURST_LEN);
    localparam logic [5:0]      BLM1      = 6'(BURST_LEN - 1);

    state_t        r_state;
    state_t        w_next;
    logic          w_latch;
    logic          w_wr_ok;
    logic          w_rd_ok;
    logic          w_pick_rd;
    logic          w_issue_rd;
    logic          w_pop;
    logic [AW-1:0] w_wr_cat;
    logic [AW-1:0] w_rd_cat;

    logic [6:0]    r_rd_resv;
    logic          r_grant_rd;
    logic          r_cmd_en;
    logic          r_wr_ack;
    logic          r_rd_ack;
    logic          r_busy;
    logic [2:0]    r_instr;
    logic [5:0]    r_bl;
    logic [29:0]   r_addr;

    assign w_wr_ok = i_calib_done & i_wr_req & ({1'b0, iv_p_wr_count} >= BL8);
    // Reads must fit in the read FIFO counting words already promised to earlier reads.
    assign w_rd_ok = i_calib_done & i_rd_req & (({1'b0, r_rd_resv} + BL8) <= DEPTH8);

`ifdef FB_ARB_ROUND_ROBIN_EN
    logic r_last_rd;

    assign w_pick_rd = w_rd_ok & (~w_wr_ok | ~r_last_rd);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_last_rd <= 1'b1;
        end else if (r_state == S_CMD) begin
            r_last_rd <= r_grant_rd;
        end
    end
`else
    assign w_pick_rd = w_rd_ok;
`endif

    assign w_wr_cat = {iv_wr_frame, iv_wr_offset} & ADDR_MASK;
    assign w_rd_cat = {iv_rd_frame, iv_rd_offset} & ADDR_MASK;

    always_comb begin
        w_next  = r_state;
        w_latch = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_wr_ok || w_rd_ok) begin
                    w_latch = 1'b1;
                    w_next  = S_WAIT;
                end
            end
            S_WAIT:  if (!i_p_cmd_full) w_next = S_CMD;
            S_CMD:   w_next = S_GAP;
            S_GAP:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state  <= S_IDLE;
            r_cmd_en <= 1'b0;
            r_wr_ack <= 1'b0;
            r_rd_ack <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_cmd_en <= (w_next == S_CMD);
            r_wr_ack <= (w_next == S_CMD) & ~r_grant_rd;
            r_rd_ack <= (w_next == S_CMD) &  r_grant_rd;
            r_busy   <= (w_next != S_IDLE);
        end
    end

    // Command fields freeze at grant and stay put through the strobe, even under back-pressure.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_grant_rd <= 1'b0;
            r_instr    <= 3'b000;
            r_bl       <= 6'd0;
            r_addr     <= 30'd0;
        end else if (w_latch) begin
            r_grant_rd <= w_pick_rd;
            r_instr    <= w_pick_rd ? 3'b001 : 3'b000;
            r_bl       <= BLM1;
            r_addr     <= w_pick_rd ? 30'(w_rd_cat) : 30'(w_wr_cat);
        end
    end

    assign w_issue_rd = r_cmd_en & r_grant_rd;
    assign w_pop      = i_p_rd_en & (r_rd_resv != 7'd0);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rd_resv <= 7'd0;
        end else if (w_issue_rd && w_pop) begin
            r_rd_resv <= r_rd_resv + BL7 - 7'd1;
        end else if (w_issue_rd) begin
            r_rd_resv <= r_rd_resv + BL7;
        end else if (w_pop) begin
            r_rd_resv <= r_rd_resv - 7'd1;
        end
    end

    assign o_p_cmd_en         = r_cmd_en;
    assign o_wr_ack           = r_wr_ack;
    assign o_rd_ack           = r_rd_ack;
    assign ov_p_cmd_instr     = r_instr;
    assign ov_p_cmd_bl        = r_bl;
    assign ov_p_cmd_byte_addr = r_addr;
    assign o_busy             = r_busy;

endmodule
